// File: rtl/fattree_adaptive_route_pipe_if.sv
// Header-in / route-out handshake bundle for the fat-tree route-compute stage.
// The slave side is the route stage; the master side is the decoder plus allocator.
interface fattree_adaptive_route_pipe_if #(
    parameter int K    = 2,
    parameter int L    = 2,
    parameter int CRDw = 3
);
    localparam int Kw   = (K <= 1) ? 1 : $clog2(K);
    localparam int Lw   = (L <= 1) ? 1 : $clog2(L);
    localparam int LKw  = L * Kw;
    localparam int DSPw = (2 * K <= 1) ? 1 : $clog2(2 * K);

    logic              in_valid;
    logic              in_ready;
    logic [LKw-1:0]    current_addr_encoded;
    logic [Lw-1:0]     current_level;
    logic [LKw-1:0]    dest_addr_encoded;
    logic [K*CRDw-1:0] up_credit;
    logic              out_valid;
    logic              out_ready;
    logic [DSPw-1:0]   destport_encoded;
    logic              out_is_up;
    logic [Kw-1:0]     up_rr_ptr;

    modport master (
        output in_valid, current_addr_encoded, current_level, dest_addr_encoded,
               up_credit, out_ready,
        input  in_ready, out_valid, destport_encoded, out_is_up, up_rr_ptr
    );

    modport slave (
        input  in_valid, current_addr_encoded, current_level, dest_addr_encoded,
               up_credit, out_ready,
        output in_ready, out_valid, destport_encoded, out_is_up, up_rr_ptr
    );
endinterface

// File: rtl/fattree_adaptive_route_pipe.sv
// Fat-tree route compute: deterministic down routing by destination digit, adaptive
// (max-credit, round-robin tie-break) or pure round-robin up routing, one registered stage.
module fattree_adaptive_route_pipe #(
    parameter int    K           = 2,
    parameter int    L           = 2,
    parameter string UP_SEL_MODE = "ADAPT",
    parameter int    CRDw        = 3
) (
    input  logic                          clk,
    input  logic                          reset,
    fattree_adaptive_route_pipe_if.slave  port
);
    localparam int Kw   = (K <= 1) ? 1 : $clog2(K);
    localparam int Lw   = (L <= 1) ? 1 : $clog2(L);
    localparam int DSPw = (2 * K <= 1) ? 1 : $clog2(2 * K);

    localparam bit              RR_MODE  = (UP_SEL_MODE == "RR");
    localparam logic [Lw-1:0]   ROOT_LVL = Lw'(L - 1);
    localparam logic [Kw-1:0]   LAST_UP  = Kw'(K - 1);
    localparam logic [DSPw-1:0] UP_BASE  = DSPw'(K);

    logic            out_valid_q, out_valid_d;
    logic [DSPw-1:0] destport_q, destport_d;
    logic            out_is_up_q, out_is_up_d;
    logic [Kw-1:0]   rr_ptr_q, rr_ptr_d;

    logic            accept;
    logic [Lw-1:0]   lvl_eff;
    logic            go_up;
    logic [Kw-1:0]   down_digit;
    logic [Kw-1:0]   sel_up;
    logic [CRDw-1:0] best_crd;

    assign port.in_ready         = !out_valid_q || port.out_ready;
    assign accept                = port.in_valid && port.in_ready;
    assign port.out_valid        = out_valid_q;
    assign port.destport_encoded = destport_q;
    assign port.out_is_up        = out_is_up_q;
    assign port.up_rr_ptr        = rr_ptr_q;

    // Levels at or above the root clamp to the root, which has no up ports.
    always_comb begin
        lvl_eff    = (port.current_level >= ROOT_LVL) ? ROOT_LVL : port.current_level;
        down_digit = '0;
        go_up      = 1'b0;
        for (int i = 0; i < L; i++) begin
            if (lvl_eff == Lw'(i))
                down_digit = port.dest_addr_encoded[i*Kw +: Kw];
        end
        for (int i = 1; i < L; i++) begin
            if (lvl_eff < Lw'(i) &&
                port.current_addr_encoded[(i-1)*Kw +: Kw] != port.dest_addr_encoded[i*Kw +: Kw])
                go_up = 1'b1;
        end
    end

    // Scanning from the pointer with a strict compare keeps the first maximum as the tie winner;
    // with no credit anywhere the pointer itself wins.
    always_comb begin
        sel_up   = rr_ptr_q;
        best_crd = '0;
        if (!RR_MODE) begin
            for (int s = 0; s < K; s++) begin
                int idx;
                idx = int'(rr_ptr_q) + s;
                if (idx >= K) idx = idx - K;
                if (port.up_credit[idx*CRDw +: CRDw] > best_crd) begin
                    best_crd = port.up_credit[idx*CRDw +: CRDw];
                    sel_up   = Kw'(idx);
                end
            end
        end
    end

    always_comb begin
        out_valid_d = out_valid_q;
        destport_d  = destport_q;
        out_is_up_d = out_is_up_q;
        rr_ptr_d    = rr_ptr_q;
        if (accept) begin
            out_valid_d = 1'b1;
            out_is_up_d = go_up;
            if (go_up) begin
                destport_d = UP_BASE + DSPw'(sel_up);
                rr_ptr_d   = (sel_up == LAST_UP) ? '0 : sel_up + 1'b1;
            end else begin
                destport_d = DSPw'(down_digit);
            end
        end else if (port.out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out_valid_q <= 1'b0;
            destport_q  <= '0;
            out_is_up_q <= 1'b0;
            rr_ptr_q    <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            destport_q  <= destport_d;
            out_is_up_q <= out_is_up_d;
            rr_ptr_q    <= rr_ptr_d;
        end
    end
endmodule

// File: tb/tb_fattree_adaptive_route_pipe.sv
// Bench for the fat-tree route stage: K=2/L=3 adaptive instance plus a K=3/L=2 round-robin instance.
module tb_fattree_adaptive_route_pipe;
    localparam int K = 2, L = 3, CRDw = 3;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    fattree_adaptive_route_pipe_if #(.K(K), .L(L), .CRDw(CRDw)) rif ();
    fattree_adaptive_route_pipe_if #(.K(3), .L(2), .CRDw(3))    rif3 ();

    fattree_adaptive_route_pipe #(.K(K), .L(L), .UP_SEL_MODE("ADAPT"), .CRDw(CRDw)) dut (
        .clk(clk), .reset(reset), .port(rif)
    );
    fattree_adaptive_route_pipe #(.K(3), .L(2), .UP_SEL_MODE("RR"), .CRDw(3)) dut3 (
        .clk(clk), .reset(reset), .port(rif3)
    );

    int checks = 0;
    int errors = 0;

    int m_valid, m_dest, m_up, m_ptr;
    int m3_valid, m3_dest, m3_up, m3_ptr;
    int cr[4];
    int cr3[4];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic int dig(input int a, input int i, input int kw);
        return (a >> (i * kw)) & ((1 << kw) - 1);
    endfunction

    // Routing decision straight from the rules: up if any higher level differs, else the
    // destination digit at this level; up port by highest credit, first from the pointer on ties.
    function automatic void ref_route(input int k, input int kw, input int l, input int rr,
                                      input int lvl, input int cur, input int dest, input int ptr,
                                      input int c[4], output int dp, output int up, output int nptr);
        int best, sel, eff;
        up = 0;
        for (int i = 1; i < l; i++)
            if (lvl < i && dig(cur, i - 1, kw) != dig(dest, i, kw)) up = 1;
        nptr = ptr;
        if (up == 0) begin
            eff = (lvl > l - 1) ? l - 1 : lvl;
            dp  = dig(dest, eff, kw);
        end else begin
            best = 0;
            for (int j = 0; j < k; j++) if (c[j] > best) best = c[j];
            sel = ptr;
            if (rr == 0 && best > 0) begin
                for (int s = 0; s < k; s++) begin
                    if (c[(ptr + s) % k] == best) begin
                        sel = (ptr + s) % k;
                        break;
                    end
                end
            end
            dp   = k + sel;
            nptr = (sel + 1) % k;
        end
    endfunction

    task automatic set_credits();
        for (int j = 0; j < K; j++) rif.up_credit[j*3 +: 3] = 3'(cr[j]);
        for (int j = 0; j < 3; j++) rif3.up_credit[j*3 +: 3] = 3'(cr3[j]);
    endtask

    task automatic model_reset();
        m_valid = 0; m_dest = 0; m_up = 0; m_ptr = 0;
        m3_valid = 0; m3_dest = 0; m3_up = 0; m3_ptr = 0;
    endtask

    task automatic check_outputs();
        check("out_valid", rif.out_valid, m_valid);
        check("destport", rif.destport_encoded, m_dest);
        check("out_is_up", rif.out_is_up, m_up);
        check("up_rr_ptr", rif.up_rr_ptr, m_ptr);
        check("k3_out_valid", rif3.out_valid, m3_valid);
        check("k3_destport", rif3.destport_encoded, m3_dest);
        check("k3_up_rr_ptr", rif3.up_rr_ptr, m3_ptr);
    endtask

    // One clock with the currently driven inputs; starts and ends 1 time unit after an edge.
    task automatic cycle();
        int rdy, rdy3, dp, up, np;
        #1;
        rdy  = (m_valid == 0 || rif.out_ready) ? 1 : 0;
        rdy3 = (m3_valid == 0 || rif3.out_ready) ? 1 : 0;
        check("in_ready", rif.in_ready, rdy);
        check("k3_in_ready", rif3.in_ready, rdy3);
        if (rif.in_valid && rdy == 1) begin
            ref_route(K, 1, L, 0, int'(rif.current_level), int'(rif.current_addr_encoded),
                      int'(rif.dest_addr_encoded), m_ptr, cr, dp, up, np);
            m_valid = 1; m_dest = dp; m_up = up; m_ptr = np;
        end else if (rif.out_ready) begin
            m_valid = 0;
        end
        if (rif3.in_valid && rdy3 == 1) begin
            ref_route(3, 2, 2, 1, int'(rif3.current_level), int'(rif3.current_addr_encoded),
                      int'(rif3.dest_addr_encoded), m3_ptr, cr3, dp, up, np);
            m3_valid = 1; m3_dest = dp; m3_up = up; m3_ptr = np;
        end else if (rif3.out_ready) begin
            m3_valid = 0;
        end
        @(posedge clk);
        #1;
        check_outputs();
    endtask

    task automatic hdr(input int vld, input int lvl, input int cur, input int dest);
        rif.in_valid             = vld[0];
        rif.current_level        = 2'(lvl);
        rif.current_addr_encoded = 3'(cur);
        rif.dest_addr_encoded    = 3'(dest);
    endtask

    // Asynchronous reset pulse placed mid-cycle; outputs must clear before any clock edge.
    task automatic reset_pulse();
        #2;
        reset = 1'b0;
        #1;
        model_reset();
        check("rst_out_valid", rif.out_valid, 0);
        check("rst_ptr", rif.up_rr_ptr, 0);
        check_outputs();
        reset = 1'b1;
    endtask

    initial begin
        reset = 1'b0;
        model_reset();
        for (int j = 0; j < 4; j++) begin cr[j] = 0; cr3[j] = 0; end
        hdr(0, 0, 0, 0);
        rif.out_ready  = 1'b1;
        rif3.in_valid  = 1'b0;
        rif3.out_ready = 1'b1;
        rif3.current_level        = '0;
        rif3.current_addr_encoded = '0;
        rif3.dest_addr_encoded    = '0;
        set_credits();

        #23;
        check("reset_out_valid", rif.out_valid, 0);
        check("reset_destport", rif.destport_encoded, 0);
        check("reset_is_up", rif.out_is_up, 0);
        check("reset_ptr", rif.up_rr_ptr, 0);
        check("reset_in_ready", rif.in_ready, 1);
        reset = 1'b1;
        @(posedge clk);
        #1;

        // T1: down by destination digit at level 0
        hdr(1, 0, 3'b010, 3'b101);
        cycle();
        check("T1_dest", rif.destport_encoded, 1);
        check("T1_up", rif.out_is_up, 0);
        check("T1_ptr", rif.up_rr_ptr, 0);

        // T2: adaptive up, port 0 has more credit
        cr[0] = 4; cr[1] = 1; set_credits();
        hdr(1, 0, 3'b010, 3'b111);
        cycle();
        check("T2_dest", rif.destport_encoded, 2);
        check("T2_up", rif.out_is_up, 1);
        check("T2_ptr", rif.up_rr_ptr, 1);

        // T4: backpressure holds the result, then back-to-back accept
        rif.out_ready = 1'b0;
        hdr(1, 0, 3'b010, 3'b101);
        for (int i = 0; i < 3; i++) begin
            cycle();
            check("T4_hold_ready", rif.in_ready, 0);
            check("T4_hold_dest", rif.destport_encoded, 2);
        end
        rif.out_ready = 1'b1;
        cycle();
        check("T4_next_valid", rif.out_valid, 1);
        check("T4_next_dest", rif.destport_encoded, 1);

        // T3: zero credits alternate between up ports from a fresh pointer
        reset_pulse();
        cr[0] = 0; cr[1] = 0; set_credits();
        hdr(1, 0, 3'b010, 3'b111);
        for (int i = 0; i < 4; i++) begin
            cycle();
            check("T3_dest", rif.destport_encoded, 2 + (i % 2));
            check("T3_ptr", rif.up_rr_ptr, (i + 1) % 2);
        end

        // T5: root always routes down, pointer untouched
        hdr(1, 2, 3'b010, 3'b100);
        cycle();
        check("T5_dest", rif.destport_encoded, 1);
        check("T5_up", rif.out_is_up, 0);
        check("T5_ptr", rif.up_rr_ptr, 0);
        hdr(1, 3, 3'b000, 3'b110);
        cycle();
        check("T5_beyond_root_dest", rif.destport_encoded, 1);

        // T6: reset during a pending up result with pointer at 1
        hdr(1, 0, 3'b010, 3'b111);
        cycle();
        check("T6_pre_ptr", rif.up_rr_ptr, 1);
        check("T6_pre_valid", rif.out_valid, 1);
        hdr(0, 0, 0, 0);
        reset_pulse();

        // Round-robin K=3: pointer wraps 2 -> 0, credits ignored
        rif3.in_valid             = 1'b1;
        rif3.current_level        = 1'b0;
        rif3.current_addr_encoded = 4'b0000;
        rif3.dest_addr_encoded    = 4'b0100;
        for (int i = 0; i < 3; i++) begin
            cr3[0] = 7; cr3[1] = $urandom_range(0, 7); cr3[2] = $urandom_range(0, 7);
            set_credits();
            cycle();
            check("RR3_dest", rif3.destport_encoded, 3 + i);
            check("RR3_ptr", rif3.up_rr_ptr, (i + 1) % 3);
        end
        rif3.in_valid = 1'b0;

        // Random traffic with backpressure, ties, zero credits and out-of-range levels
        for (int n = 0; n < 300; n++) begin
            hdr(($urandom % 4) != 0 ? 1 : 0, $urandom_range(0, 3),
                $urandom_range(0, 7), $urandom_range(0, 7));
            rif.out_ready = 1'(($urandom % 3) != 0);
            for (int j = 0; j < K; j++)
                cr[j] = ($urandom % 2 == 0) ? $urandom_range(0, 2) : $urandom_range(0, 7);
            rif3.in_valid             = 1'(($urandom % 2) != 0);
            rif3.out_ready            = 1'(($urandom % 3) != 0);
            rif3.current_level        = 1'($urandom_range(0, 1));
            rif3.current_addr_encoded = 4'({2'($urandom_range(0, 2)), 2'($urandom_range(0, 2))});
            rif3.dest_addr_encoded    = 4'({2'($urandom_range(0, 2)), 2'($urandom_range(0, 2))});
            for (int j = 0; j < 3; j++) cr3[j] = $urandom_range(0, 7);
            set_credits();
            cycle();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
